// File: rtl/mutex_rr_scheduler.sv
// Round-robin mutual-exclusion scheduler: four edge-triggered requesters share
// one downstream resource; each grant runs GRANT -> WAIT -> FREE before the
// arbiter looks at the pending set again.
module mutex_rr_scheduler #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [3:0]            i_drive,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  input  logic [DATA_WIDTH-1:0] i_data2,
  input  logic [DATA_WIDTH-1:0] i_data3,
  input  logic                  i_freeNext,
  output logic [3:0]            o_free,
  output logic                  o_driveNext,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [3:0]            o_grant,
  output logic                  o_busy,
  output logic                  o_timeout
);

  // Counter holds 0..TIMEOUT_CYCLES; a disabled timeout still needs one bit.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // Release fires on the WAIT cycle that would bring the count to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FREE  = 2'd3
  } state_t;

  state_t                  state;
  logic [3:0]              pend;
  logic [3:0]              prev;
  logic [1:0]              ptr;
  logic [1:0]              sel;
  logic [CNT_W-1:0]        cnt;

  logic [3:0]              rise;
  logic                    pick_valid;
  logic [1:0]              pick;
  logic [1:0]              cand;
  logic [DATA_WIDTH-1:0]   pick_data;

  // Rising edges of the drive levels relative to last cycle's sample.
  assign rise = i_drive & ~prev;

  // Rotating priority search starting just after the last served requester.
  always_comb begin
    pick_valid = 1'b0;
    pick       = ptr;
    cand       = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!pick_valid && pend[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // Payload of the requester about to be granted.
  always_comb begin
    case (pick)
      2'd0:    pick_data = i_data0;
      2'd1:    pick_data = i_data1;
      2'd2:    pick_data = i_data2;
      default: pick_data = i_data3;
    endcase
  end

  // Request capture, arbitration FSM and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      pend        <= '0;
      prev        <= '0;
      ptr         <= 2'd3;
      sel         <= 2'd0;
      cnt         <= '0;
      o_data      <= '0;
      o_grant     <= '0;
      o_free      <= '0;
      o_driveNext <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      prev        <= i_drive;
      pend        <= pend | rise;
      o_free      <= '0;
      o_driveNext <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            sel         <= pick;
            o_grant     <= 4'b0001 << pick;
            o_data      <= pick_data;
            o_driveNext <= 1'b1;
            o_busy      <= 1'b1;
            state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_freeNext) begin
            o_free <= 4'b0001 << sel;
            state  <= ST_FREE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
            cnt       <= cnt + CNT_W'(1);
            o_free    <= 4'b0001 << sel;
            o_timeout <= 1'b1;
            state     <= ST_FREE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_FREE: begin
          // A fresh edge on the served requester re-arms it rather than being lost.
          pend    <= (pend & ~(4'b0001 << sel)) | rise;
          ptr     <= sel;
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mutex_rr_scheduler.sv
// Self-checking bench for mutex_rr_scheduler: reference model plus directed scenarios.
module tb_mutex_rr_scheduler;

  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [3:0]    i_drive = '0;
  logic [DW-1:0] i_data0 = '0, i_data1 = '0, i_data2 = '0, i_data3 = '0;
  logic          i_freeNext = 1'b0;
  logic [3:0]    o_free;
  logic          o_driveNext;
  logic [DW-1:0] o_data;
  logic [3:0]    o_grant;
  logic          o_busy;
  logic          o_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  mutex_rr_scheduler #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn), .i_drive(i_drive),
    .i_data0(i_data0), .i_data1(i_data1), .i_data2(i_data2), .i_data3(i_data3),
    .i_freeNext(i_freeNext), .o_free(o_free), .o_driveNext(o_driveNext),
    .o_data(o_data), .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction phases: idle, drive cycle, waiting for completion, release cycle.
  localparam int PH_IDLE = 0, PH_DRIVE = 1, PH_WAIT = 2, PH_REL = 3;

  int            m_phase = PH_IDLE, m_sel = 0, m_ptr = 3, m_waited = 0;
  logic [3:0]    m_pend = '0, m_prev = '0, m_grant = '0, m_free = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_drv = 1'b0, m_to = 1'b0;

  int            n_phase, n_sel, n_ptr, n_waited;
  logic [3:0]    n_pend, n_rise, n_grant, n_free;
  logic [DW-1:0] n_data;
  logic          n_drv, n_to;
  bit            found;

  function automatic logic [DW-1:0] data_of(input int s);
    case (s)
      0: return i_data0;
      1: return i_data1;
      2: return i_data2;
      default: return i_data3;
    endcase
  endfunction

  always_comb begin
    n_rise   = i_drive & ~m_prev;
    n_pend   = m_pend | n_rise;
    n_phase  = m_phase;
    n_sel    = m_sel;
    n_ptr    = m_ptr;
    n_waited = m_waited;
    n_grant  = m_grant;
    n_data   = m_data;
    n_drv    = 1'b0;
    n_free   = '0;
    n_to     = m_to;
    found    = 1'b0;
    case (m_phase)
      PH_IDLE: begin
        for (int k = 1; k <= 4; k++) begin
          if (!found && m_pend[(m_ptr + k) % 4]) begin
            found = 1'b1;
            n_sel = (m_ptr + k) % 4;
          end
        end
        if (found) begin
          n_grant = 4'(1 << n_sel);
          n_data  = data_of(n_sel);
          n_drv   = 1'b1;
          n_phase = PH_DRIVE;
        end
      end
      PH_DRIVE: begin
        n_waited = 0;
        n_phase  = PH_WAIT;
      end
      PH_WAIT: begin
        if (i_freeNext) begin
          n_free[m_sel] = 1'b1;
          n_phase = PH_REL;
        end else begin
          n_waited = m_waited + 1;
          if (TO != 0 && n_waited == TO) begin
            n_free[m_sel] = 1'b1;
            n_to    = 1'b1;
            n_phase = PH_REL;
          end
        end
      end
      default: begin
        n_pend  = (m_pend & ~4'(1 << m_sel)) | n_rise;
        n_grant = '0;
        n_ptr   = m_sel;
        n_phase = PH_IDLE;
      end
    endcase
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase <= PH_IDLE; m_sel <= 0; m_ptr <= 3; m_waited <= 0;
      m_pend <= '0; m_prev <= '0; m_grant <= '0; m_free <= '0;
      m_data <= '0; m_drv <= 1'b0; m_to <= 1'b0;
    end else begin
      m_phase <= n_phase; m_sel <= n_sel; m_ptr <= n_ptr; m_waited <= n_waited;
      m_pend <= n_pend; m_prev <= i_drive; m_grant <= n_grant; m_free <= n_free;
      m_data <= n_data; m_drv <= n_drv; m_to <= n_to;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_grant",    64'(o_grant),     64'(m_grant));
      chk("cyc_data",     64'(o_data),      64'(m_data));
      chk("cyc_drive",    64'(o_driveNext), 64'(m_drv));
      chk("cyc_free",     64'(o_free),      64'(m_free));
      chk("cyc_busy",     64'(o_busy),      64'(m_phase != PH_IDLE));
      chk("cyc_timeout",  64'(o_timeout),   64'(m_to));
      chk("cyc_onehot",   64'($countones(o_grant) <= 1), 64'(1));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // which=0 waits for o_driveNext, which=1 for any o_free bit; n = ticks taken.
  task automatic wait_for(input bit which, input string name, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = which ? (o_free != 4'b0) : o_driveNext;
    end
    chk(name, 64'(seen), 64'(1));
  endtask

  function automatic int idx_of(input logic [3:0] g);
    for (int k = 0; k < 4; k++) if (g[k]) return k;
    return -1;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int order[4];
    int frees[4];
    tick(3);
    cmp_en = 1'b1;
    chk("rst_grant", 64'(o_grant), 64'h0);
    chk("rst_busy",  64'(o_busy),  64'h0);
    chk("rst_data",  64'(o_data),  64'h0);
    chk("rst_to",    64'(o_timeout), 64'h0);
    rstn = 1'b1;
    tick(2);

    // Single request from requester 2.
    i_data2 = 32'hA5A5_0002;
    i_drive = 4'b0100;
    wait_for(0, "t1_drive_seen", n);
    chk("t1_latency", 64'(n), 64'd2);
    chk("t1_grant",   64'(o_grant), 64'h4);
    chk("t1_data",    64'(o_data),  64'hA5A5_0002);
    tick(3);
    i_freeNext = 1'b1;
    wait_for(1, "t1_free_seen", n);
    chk("t1_free", 64'(o_free), 64'h4);
    i_freeNext = 1'b0;
    i_drive = 4'b0000;
    tick();
    chk("t1_free_once", 64'(o_free), 64'h0);
    chk("t1_idle",      64'(o_busy), 64'h0);
    chk("t1_data_kept", 64'(o_data), 64'hA5A5_0002);

    // All four rise together after reset: rotation 0,1,2,3.
    do_reset();
    i_data0 = 32'hD000_0000; i_data1 = 32'hD000_0001;
    i_data2 = 32'hD000_0002; i_data3 = 32'hD000_0003;
    i_drive = 4'b1111;
    for (int i = 0; i < 4; i++) frees[i] = 0;
    for (int i = 0; i < 4; i++) begin
      wait_for(0, "t2_drive_seen", n);
      order[i] = idx_of(o_grant);
      chk("t2_data", 64'(o_data), 64'(32'hD000_0000 | 32'(i)));
      tick();
      i_freeNext = 1'b1;
      wait_for(1, "t2_free_seen", n);
      for (int k = 0; k < 4; k++) frees[k] += int'(o_free[k]);
      i_freeNext = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", 64'(order[i]), 64'(i));
      chk("t2_free_count", 64'(frees[i]), 64'd1);
    end

    // Forced release on timeout.
    i_drive = 4'b0000;
    tick();
    i_drive = 4'b0001;
    wait_for(0, "t3_drive_seen", n);
    wait_for(1, "t3_free_seen", n);
    chk("t3_wait_ticks", 64'(n), 64'd5);
    chk("t3_free", 64'(o_free), 64'h1);
    chk("t3_timeout", 64'(o_timeout), 64'h1);
    i_drive = 4'b0000;
    tick(2);
    chk("t3_timeout_sticky", 64'(o_timeout), 64'h1);

    // Requester 1 re-raises in its release cycle while 3 is pending.
    i_drive = 4'b1010;
    wait_for(0, "t4_drive_seen", n);
    chk("t4_first", 64'(idx_of(o_grant)), 64'd1);
    i_drive = 4'b1000;
    tick();
    i_freeNext = 1'b1;
    wait_for(1, "t4_free_seen", n);
    i_drive = 4'b1010;
    i_freeNext = 1'b0;
    wait_for(0, "t4_drive2_seen", n);
    chk("t4_second", 64'(idx_of(o_grant)), 64'd3);
    tick();
    i_freeNext = 1'b1;
    wait_for(1, "t4_free2_seen", n);
    i_freeNext = 1'b0;
    wait_for(0, "t4_drive3_seen", n);
    chk("t4_third", 64'(idx_of(o_grant)), 64'd1);
    tick();
    i_freeNext = 1'b1;
    wait_for(1, "t4_free3_seen", n);
    i_freeNext = 1'b0;
    chk("t4_timeout_sticky", 64'(o_timeout), 64'h1);

    // Reset during WAIT with requester 2 granted.
    i_drive = 4'b0000;
    tick();
    i_drive = 4'b0100;
    wait_for(0, "t5_drive_seen", n);
    tick();
    chk("t5_grant_before", 64'(o_grant), 64'h4);
    #1 rstn = 1'b0;
    #1;
    chk("t5_rst_grant", 64'(o_grant), 64'h0);
    chk("t5_rst_free",  64'(o_free), 64'h0);
    chk("t5_rst_busy",  64'(o_busy), 64'h0);
    chk("t5_rst_data",  64'(o_data), 64'h0);
    chk("t5_rst_drive", 64'(o_driveNext), 64'h0);
    chk("t5_rst_to",    64'(o_timeout), 64'h0);
    tick();
    rstn = 1'b1;
    wait_for(0, "t5_regrant_seen", n);
    chk("t5_regrant_latency", 64'(n), 64'd2);
    chk("t5_regrant", 64'(o_grant), 64'h4);
    tick();
    i_freeNext = 1'b1;
    wait_for(1, "t5_free_seen", n);
    chk("t5_free", 64'(o_free), 64'h4);
    i_freeNext = 1'b0;
    i_drive = 4'b0000;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
